// File: rtl/cpu_pkg.sv
// Shared definitions for the multicycle core: MIPS opcode encodings and the
// fetch unit state type.
package cpu_pkg;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;

   typedef enum logic [1:0] {
      RST   = 2'd0,
      FETCH = 2'd1,
      HOLD  = 2'd2
   } ifu_state_t;

endpackage

// File: rtl/pc_next_calc.sv
// Combinational next-PC selection: sequential, taken branch, or (with
// IFU_JUMP_EN defined) an absolute J-type jump.
module pc_next_calc
   import cpu_pkg::*;
#(
   parameter int ADDR_W = 32
) (
   input  logic [ADDR_W-1:0] pc,
   input  logic [31:0]       ir,
   input  logic              branch,
   input  logic              zero,
   output logic [ADDR_W-1:0] pc_plus4,
   output logic [ADDR_W-1:0] next_pc
);

`ifdef IFU_JUMP_EN
   localparam bit JUMP_EN = 1'b1;
`else
   localparam bit JUMP_EN = 1'b0;
`endif

   logic [ADDR_W-1:0] branch_off;
   logic [ADDR_W-1:0] branch_target;
   logic [ADDR_W-1:0] jump_target;
   logic              is_jump;

   // Word offset is sign-extended then scaled by 4; adds wrap modulo 2^ADDR_W.
   assign pc_plus4      = pc + ADDR_W'(4);
   assign branch_off    = {{(ADDR_W-18){ir[15]}}, ir[15:0], 2'b00};
   assign branch_target = pc_plus4 + branch_off;
   assign jump_target   = {pc_plus4[ADDR_W-1:28], ir[25:0], 2'b00};
   assign is_jump       = JUMP_EN && (ir[31:26] == OP_J);

   always_comb begin
      next_pc = pc_plus4;
      if (is_jump)
         next_pc = jump_target;
      else if (branch && zero)
         next_pc = branch_target;
   end

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch unit: fetches into IR, hands it to decode, picks next PC.
// Optional J-type support is enabled by defining IFU_JUMP_EN.
module inst_fetch_unit #(
   parameter int                ADDR_W   = 32,
   parameter int                DATA_W   = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000
) (
   input  logic              clk,
   input  logic              rst_n,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic              imem_ack,
   input  logic [DATA_W-1:0] imem_rdata,
   output logic              inst_valid,
   input  logic              inst_ready,
   output logic [DATA_W-1:0] inst,
   output logic [5:0]        ctl_op,
   output logic [ADDR_W-1:0] pc,
   output logic [ADDR_W-1:0] pc_plus4,
   input  logic              branch,
   input  logic              zero
);
   import cpu_pkg::*;

   localparam logic [ADDR_W-1:0] RESET_PC_ALIGNED = RESET_PC & ~ADDR_W'(3);

   ifu_state_t        state;
   ifu_state_t        state_next;
   logic [DATA_W-1:0] ir;
   logic [ADDR_W-1:0] pc_q;
   logic [ADDR_W-1:0] next_pc;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= RST;
      else
         state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         RST:     state_next = FETCH;
         FETCH:   if (imem_ack)   state_next = HOLD;
         HOLD:    if (inst_ready) state_next = FETCH;
         default: state_next = RST;
      endcase
   end

   // IR only loads on an ack during FETCH; acks in RST or HOLD are dropped.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q <= RESET_PC_ALIGNED;
         ir   <= '0;
      end else begin
         if (state == FETCH && imem_ack)
            ir <= imem_rdata;
         if (state == HOLD && inst_ready)
            pc_q <= next_pc;
      end
   end

   pc_next_calc #(
      .ADDR_W (ADDR_W)
   ) u_pc_next_calc (
      .pc       (pc_q),
      .ir       (ir[31:0]),
      .branch   (branch),
      .zero     (zero),
      .pc_plus4 (pc_plus4),
      .next_pc  (next_pc)
   );

   assign imem_req   = (state == FETCH);
   assign imem_addr  = pc_q;
   assign inst_valid = (state == HOLD);
   assign inst       = ir;
   assign ctl_op     = ir[31:26];
   assign pc         = pc_q;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed self-checking bench for inst_fetch_unit; a second instance with a
// top-of-memory RESET_PC covers PC wrap. Expected jump target follows IFU_JUMP_EN.
module tb_inst_fetch_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        imem_req, inst_valid;
   logic [31:0] imem_addr, inst, pc, pc_plus4;
   logic [5:0]  ctl_op;
   logic        imem_ack, inst_ready, branch, zero;
   logic [31:0] imem_rdata;

   logic        w_req, w_valid, w_ack, w_ready, w_branch, w_zero;
   logic [31:0] w_addr, w_inst, w_pc, w_pc_plus4, w_rdata;
   logic [5:0]  w_op;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   inst_fetch_unit dut (
      .clk(clk), .rst_n(rst_n),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .ctl_op(ctl_op),
      .pc(pc), .pc_plus4(pc_plus4), .branch(branch), .zero(zero)
   );

   inst_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
      .clk(clk), .rst_n(rst_n),
      .imem_req(w_req), .imem_addr(w_addr), .imem_ack(w_ack), .imem_rdata(w_rdata),
      .inst_valid(w_valid), .inst_ready(w_ready), .inst(w_inst), .ctl_op(w_op),
      .pc(w_pc), .pc_plus4(w_pc_plus4), .branch(w_branch), .zero(w_zero)
   );

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Starts in FETCH: stall for 'waits' cycles, then ack with 'data'.
   task automatic fetch(input logic [31:0] data, input int waits, input logic [31:0] addr);
      for (int i = 0; i < waits; i++) begin
         checkOutput("stall_req", imem_req, 1'b1);
         checkOutput("stall_addr", imem_addr, addr);
         step();
      end
      checkOutput("fetch_req", imem_req, 1'b1);
      checkOutput("fetch_addr", imem_addr, addr);
      imem_ack   = 1'b1;
      imem_rdata = data;
      step();
      imem_ack   = 1'b0;
      imem_rdata = 32'h0;
      checkOutput("hold_valid", inst_valid, 1'b1);
      checkOutput("hold_req", imem_req, 1'b0);
      checkOutput("hold_inst", inst, data);
      checkOutput("hold_op", ctl_op, {26'h0, data[31:26]});
      checkOutput("hold_pc", pc, addr);
      checkOutput("hold_pc4", pc_plus4, addr + 32'd4);
   endtask

   // Starts in HOLD: accept with branch/zero, expect next fetch at exp_next.
   task automatic accept(input logic br, input logic z, input logic [31:0] exp_next);
      inst_ready = 1'b1;
      branch     = br;
      zero       = z;
      step();
      inst_ready = 1'b0;
      branch     = 1'b0;
      zero       = 1'b0;
      checkOutput("acc_valid", inst_valid, 1'b0);
      checkOutput("acc_req", imem_req, 1'b1);
      checkOutput("acc_addr", imem_addr, exp_next);
   endtask

   initial begin
      logic [31:0] jump_exp;
      rst_n = 1'b0;
      imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
      inst_ready = 1'b0; branch = 1'b0; zero = 1'b0;
      w_ack = 1'b0; w_rdata = 32'h0; w_ready = 1'b0; w_branch = 1'b0; w_zero = 1'b0;
      #2;
      $display("[TB] reset checks");
      checkOutput("rst_req", imem_req, 1'b0);
      checkOutput("rst_valid", inst_valid, 1'b0);
      checkOutput("rst_pc", pc, 32'h0);
      checkOutput("rst_inst", inst, 32'h0);
      checkOutput("rst_op", ctl_op, 6'b000000);
      #10 rst_n = 1'b1;
      // ack still high during the RST->FETCH edge; it must be dropped
      step();
      imem_ack = 1'b0;
      checkOutput("rst_ack_ignored", inst, 32'h0);
      checkOutput("post_rst_valid", inst_valid, 1'b0);

      fetch(32'h8C01_0004, 2, 32'h0000_0000);
      accept(1'b0, 1'b0, 32'h0000_0004);

      fetch(32'h1000_FFFF, 0, 32'h0000_0004);
      accept(1'b1, 1'b1, 32'h0000_0004);

      fetch(32'h1000_0003, 1, 32'h0000_0004);
      imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF; branch = 1'b1; zero = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();
         checkOutput("stay_valid", inst_valid, 1'b1);
         checkOutput("stay_req", imem_req, 1'b0);
         checkOutput("stay_inst", inst, 32'h1000_0003);
         checkOutput("stay_pc", pc, 32'h0000_0004);
      end
      imem_ack = 1'b0; imem_rdata = 32'h0;
      accept(1'b1, 1'b0, 32'h0000_0008);

      fetch(32'h1000_0003, 0, 32'h0000_0008);
      accept(1'b1, 1'b1, 32'h0000_0018);

`ifdef IFU_JUMP_EN
      jump_exp = 32'h0040_0040;
`else
      jump_exp = 32'h0000_001C;
`endif
      fetch(32'h0810_0010, 0, 32'h0000_0018);
      accept(1'b0, 1'b0, jump_exp);

      // reset while the memory is stalling a fetch
      step();
      checkOutput("pre_rst_req", imem_req, 1'b1);
      #3 rst_n = 1'b0;
      #1;
      checkOutput("async_req", imem_req, 1'b0);
      checkOutput("async_pc", pc, 32'h0);
      imem_ack = 1'b1; imem_rdata = 32'h1234_5678;
      step();
      rst_n = 1'b1;
      step();
      imem_ack = 1'b0; imem_rdata = 32'h0;
      checkOutput("restart_inst", inst, 32'h0);
      checkOutput("restart_valid", inst_valid, 1'b0);
      fetch(32'h8C01_0004, 1, 32'h0000_0000);

      // wrap instance: fetch from top of memory, accept, expect address 0
      checkOutput("wrap_req", w_req, 1'b1);
      checkOutput("wrap_addr", w_addr, 32'hFFFF_FFFC);
      w_ack = 1'b1; w_rdata = 32'h8C01_0004;
      step();
      w_ack = 1'b0;
      checkOutput("wrap_valid", w_valid, 1'b1);
      checkOutput("wrap_pc4", w_pc_plus4, 32'h0);
      w_ready = 1'b1;
      step();
      w_ready = 1'b0;
      checkOutput("wrap_next", w_addr, 32'h0);
      checkOutput("wrap_req2", w_req, 1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #20000;
      $display("[TB] FAIL timeout got=running exp=finished");
      $fatal(1);
   end

endmodule

// File: doc/inst_fetch_unit.md
Name: inst_fetch_unit

Overview:
- Producer side of the control interface: fetches instruction words from instruction memory.
- Holds each word in an instruction register (IR) and presents the opcode field as ctl_op to the operation decoder.
- Consumes the decoder's branch output together with the ALU zero flag to select the next PC.
- Sits between instruction memory and the decoder/datapath in the multicycle core.

Parameters:
- ADDR_W, 32, PC / instruction memory address width
- DATA_W, 32, instruction word width (fixed MIPS encoding; only 32 is supported)
- RESET_PC, 32'h0000_0000, PC value loaded on reset

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- imem_req  out  1  instruction memory read request
- imem_addr  out  ADDR_W  word-aligned fetch address (= pc)
- imem_ack  in  1  memory has imem_rdata valid this cycle
- imem_rdata  in  DATA_W  fetched instruction word
- inst_valid  out  1  IR holds an instruction for the decoder/datapath
- inst_ready  in  1  downstream consumes IR this cycle
- inst  out  DATA_W  IR contents
- ctl_op  out  6  IR[31:26], the opcode driven to the operation decoder
- pc  out  ADDR_W  address of the instruction in IR
- pc_plus4  out  ADDR_W  pc + 4
- branch  in  1  branch control from the decoder
- zero  in  1  ALU zero flag

Behaviour:
- Reset (async assert, sync deassert is external):
  - state=RST, pc=RESET_PC, IR=0, imem_req=0, inst_valid=0.
  - ctl_op=6'b000000, i.e. RTYPE encoding, harmless because inst_valid=0.
- FSM states RST, FETCH, HOLD:
  - RST -> FETCH unconditionally on the next edge. An imem_ack seen while in RST is ignored.
  - FETCH: imem_req=1, imem_addr=pc, held stable until ack.
    - On the edge where imem_ack=1: IR<=imem_rdata, -> HOLD.
    - Fetch latency is 1 + memory wait cycles. An ack in the first FETCH cycle gives inst_valid on the following cycle.
  - HOLD: imem_req=0, inst_valid=1. IR and pc are stable until accepted.
    - On the edge where inst_ready=1: pc<=next_pc, -> FETCH.
    - With inst_ready=0 the block stays in HOLD indefinitely.
- next_pc, computed from branch/zero sampled in the accept cycle:
  - branch&zero -> pc_plus4 + (sign_extend(IR[15:0]) << 2)
  - otherwise -> pc_plus4
- Arithmetic: all adds modulo 2^ADDR_W.
  - pc=32'hFFFF_FFFC wraps to 0.
  - Negative offsets wrap correctly.
  - pc[1:0] is always 2'b00.
- branch/zero are ignored outside the HOLD&inst_ready cycle.
- An imem_ack arriving in HOLD is ignored; memory must not ack without a request.
- Reset mid-fetch: imem_req drops immediately (async). The pending fetch is discarded and a fresh fetch of RESET_PC starts.

Optional Feature:
- Macro IFU_JUMP_EN.
- When defined: if ctl_op==6'b000010 (J) at accept, next_pc = {pc_plus4[31:28], IR[25:0], 2'b00}. J takes priority over branch&zero.
- When undefined: opcode 000010 is treated like any non-branch and next_pc = pc_plus4.

Decomposition:
- Shared package cpu_pkg:
  - Opcode constants OP_RTYPE=6'b000000, OP_LW=6'b100011, OP_SW=6'b101011, OP_BEQ=6'b000100, OP_J=6'b000010.
  - Enum ifu_state_t {RST, FETCH, HOLD}.
- One natural sub-module: pc_next_calc, a combinational block (pc, IR, branch, zero -> pc_plus4, next_pc).

Test Plan:
- Reset, then ack with rdata=32'h8C010004 after 2 wait cycles -> imem_addr=0; inst_valid rises; ctl_op=6'b100011; pc=0.
- Accept with branch=0 -> next imem_addr=4. Then IR=32'h1000FFFF, branch=1, zero=1 at accept -> next fetch addr = 8 + (-1<<2) = 4.
- BEQ with branch=1, zero=0 -> next fetch addr = pc+4. Hold inst_ready=0 for 5 cycles -> IR, pc, inst_valid unchanged; imem_req=0.
- RESET_PC=32'hFFFF_FFFC, accept non-branch -> next imem_addr=0 (wrap).
- Assert rst_n=0 during FETCH while memory is stalled -> imem_req=0 in the same cycle. After release, the fetch restarts at RESET_PC and a stale ack during RST is ignored.
- IFU_JUMP_EN defined, pc=32'h0040_0000, IR=32'h0810_0010 -> next imem_addr=32'h0040_0040. With the macro undefined -> 32'h0040_0004.
